// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: valid+payload pipeline boundary registers with stall, bubble, flush and counters
module pipe_stage_chain #(
  parameter int NUM_STAGES = 4,
  parameter int PAYLOAD_W  = 64,
  parameter int COLLAPSE   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [PAYLOAD_W-1:0]            in_payload,
  output logic                            in_ready,
  input  logic [NUM_STAGES-1:0]           stall_req,
  input  logic [NUM_STAGES-1:0]           flush_mask,
  output logic [NUM_STAGES-1:0]           stage_valid,
  output logic [NUM_STAGES*PAYLOAD_W-1:0] stage_payload,
  output logic [NUM_STAGES-1:0]           stage_advance,
  output logic [CNT_W-1:0]                retire_count,
  output logic [CNT_W-1:0]                stall_count
);
  localparam int N = NUM_STAGES;
  localparam int W = PAYLOAD_W;
  logic [N-1:0] es, hold, prev_hold, src_valid;
  logic [N:0] chain;
  logic [W-1:0] in_word;
  logic [N*W-1:0] src_payload;
  logic retire;
  always_comb begin
    es = stall_req & ~flush_mask;
    chain = '0;
    for (int k = N - 1; k >= 0; k--)
      chain[k] = (COLLAPSE != 0 ? stage_valid[k] : 1'b1) & (es[k] | chain[k+1]);
    hold = chain[N-1:0];
  end
  assign prev_hold     = hold << 1;
  assign src_valid     = (stage_valid << 1) | {{(N-1){1'b0}}, in_valid};
  assign in_word       = in_valid ? in_payload : '0;
  assign src_payload   = {stage_payload[(N-1)*W-1:0], in_word};
  assign in_ready      = ~hold[0];
  assign stage_advance = ~hold;
  assign retire        = stage_valid[N-1] & ~hold[N-1] & ~flush_mask[N-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid   <= '0;
      stage_payload <= '0;
      retire_count  <= '0;
      stall_count   <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (flush_mask[k] || (!hold[k] && prev_hold[k])) begin
          stage_valid[k]          <= 1'b0;
          stage_payload[k*W +: W] <= '0;
        end else if (!hold[k]) begin
          stage_valid[k]          <= src_valid[k];
          stage_payload[k*W +: W] <= src_payload[k*W +: W];
        end
      end
      if (retire && retire_count != '1) retire_count <= retire_count + 1'b1;
      if (hold[0] && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised chain of pipeline boundary registers (valid bit + payload per stage) that replaces the fixed, always-loading IF/ID, ID/EX, EX/MEM and MEM/WB latches. Adds per-stage stall requests, bubble insertion, selective flush for branch redirect, optional bubble collapsing, and saturating performance counters. It sits between the stage logic blocks of the LC-3b datapath. Payload carries IR, PC, control word and operands, packed by the instantiating level.

Parameters:
NUM_STAGES, 4, number of boundary registers; stage 0 is IF/ID, stage NUM_STAGES-1 is MEM/WB.
PAYLOAD_W, 64, payload bits per stage.
COLLAPSE, 1, 1 = bubbles absorb back-pressure; 0 = any stall freezes all upstream stages.
CNT_W, 16, performance counter width.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  fetch stage presents an instruction.
in_payload  in  PAYLOAD_W  fetch payload.
in_ready  out  1  stage 0 accepts in_payload this cycle.
stall_req  in  NUM_STAGES  bit k: consumer of stage k cannot take its content this cycle (e.g. load-use in decode, memory not ready in MEM).
flush_mask  in  NUM_STAGES  bit k: invalidate stage k at this edge.
stage_valid  out  NUM_STAGES  registered valid per stage.
stage_payload  out  NUM_STAGES*PAYLOAD_W  stage k at bits [k*PAYLOAD_W +: PAYLOAD_W].
stage_advance  out  NUM_STAGES  bit k: stage k loads new content (data or bubble) at this edge.
retire_count  out  CNT_W  instructions leaving the last stage.
stall_count  out  CNT_W  cycles with in_ready==0.

Behaviour:
- Reset (clk edge with reset=1): all stage_valid=0, all payloads=0, both counters=0. Reset overrides every other input. in_ready is 1 the first cycle after reset.
- Effective stall: es[k] = stall_req[k] & ~flush_mask[k]. A flushed stage never stalls.
- hold[k] (stage k keeps its content):
  - COLLAPSE=1: hold[N-1]=stage_valid[N-1] & es[N-1]; hold[k]=stage_valid[k] & (es[k] | hold[k+1]).
  - COLLAPSE=0: hold[k]=OR of es[j] for j>=k, regardless of valid.
- stage_advance[k] = ~hold[k]. in_ready = ~hold[0]. All purely combinational from current state and inputs.
- Per stage k, at each edge, in priority order:
  1. flush_mask[k]=1: valid<=0, payload<=0.
  2. hold[k]: unchanged.
  3. k=0: valid<=in_valid, payload<=in_valid ? in_payload : 0.
  4. k>0 and hold[k-1]: bubble, valid<=0, payload<=0.
  5. otherwise: valid<=stage_valid[k-1], payload<=stage_payload of stage k-1.
- Flush of stage 0 while in_ready=1 discards the incoming word. The fetch side sees the handshake complete and must redirect PC itself.
- Stage 0 with in_ready=1 and in_valid=0 loads a bubble.
- Bubble payload is all-zero, so a zero control word acts as a NOP. Consumers must still qualify on stage_valid.
- Simultaneous flush of stage k and stall of k+1: stage k clears and stage k+1 holds. No interaction.
- Latency with no stalls: an input accepted at edge t appears in stage k after edge t+k, and leaves the last stage at edge t+NUM_STAGES.
- retire_count increments when stage_valid[N-1] & ~hold[N-1] & ~flush_mask[N-1]. Saturates at all-ones.
- stall_count increments when in_ready==0. Saturates at all-ones.
- Reset asserted mid-stall or mid-flush: all state clears at that edge. No pending stall is remembered.

Test Plan:
- Streaming: NUM_STAGES=4, PAYLOAD_W=16, feed 0x1001..0x1008 one per cycle, no stalls -> 0x1001 in stage 3 after 4th edge; stage_valid=4'b1111 thereafter; retire_count=8 four cycles after the last input.
- MEM stall, COLLAPSE=1, full pipe: stall_req[2]=1 for 3 cycles -> stages 0-2 frozen; stage 3 gets a bubble (valid=0, payload=0) for 3 edges; in_ready=0; stall_count=3. Release -> stream resumes with no loss or duplication.
- Bubble absorption, COLLAPSE=1: stage 1 empty, stall_req[3]=1 -> stage 0 advances into stage 1 and in_ready=1 for one cycle, then 0 once stage 1 fills. Same stimulus with COLLAPSE=0 -> in_ready=0 immediately.
- Branch flush: full pipe, flush_mask=4'b0011 with in_valid=1, in_payload=0xBEEF -> stages 0,1 invalid next cycle; 0xBEEF not captured; stages 2,3 advance normally.
- Flush overrides stall: stall_req[1]=1 and flush_mask[1]=1 together -> stage 1 cleared; stage 0 not held by stage 1.
- Saturation and reset: CNT_W=4, retire 20 instructions -> retire_count=4'hF. Assert reset during an active stall -> all valids 0, counters 0, in_ready=1 next cycle.
